mips_multicycle_exec: RTL and testbench

Multi-cycle MIPS integer execute unit, the clocked successor of the single-cycle ALU/control path. It holds its own register file and accepts one 32-bit R/I-type instruction per valid/ready handshake. The instruction passes through a DECODE/EXEC/WB state machine and the result is presented on a valid/ready result port. Data width is parametrised, and the unit adds overflow and illegal-opcode detection with write suppression.

---
 rtl/mips_multicycle_exec.sv | 193 +++++++++++++++++++
 tb/tb_mips_multicycle_exec.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_exec.sv
// Multi-cycle MIPS integer execute unit: IDLE -> DECODE -> EXEC -> WB with a private register file,
// overflow/illegal-instruction detection and write suppression.
module mips_multicycle_exec #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DATA_W-1:0] result,
    output logic [4:0]        result_dst,
    output logic              result_wen,
    output logic [1:0]        result_status,
    input  logic              dbg_we,
    input  logic [4:0]        dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_PASSB, OP_ILL
    } op_t;

    state_t state, state_next;

    logic [31:0]              instr_p0;
    logic signed [DATA_W-1:0] a_p1, b_p1;
    op_t                      op_p1;
    logic [4:0]               shamt_p1, dst_p1;
    logic [DATA_W-1:0]        regs [NUM_REGS];

    function automatic logic reg_valid(input logic [4:0] addr);
        return (addr != 5'd0) && (int'(addr) < NUM_REGS);
    endfunction

    function automatic logic add_ovf(input logic signed [DATA_W-1:0] x, y, s);
        return (x[DATA_W-1] == y[DATA_W-1]) && (s[DATA_W-1] != x[DATA_W-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [DATA_W-1:0] x, y, d);
        return (x[DATA_W-1] != y[DATA_W-1]) && (d[DATA_W-1] != x[DATA_W-1]);
    endfunction

    assign instr_ready  = (state == IDLE) && rst_n;
    assign result_valid = (state == WB);
    assign dbg_rdata    = reg_valid(dbg_raddr) ? regs[dbg_raddr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (instr_valid) state_next = DECODE;
            DECODE:  state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      if (result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decode of the captured instruction word
    logic [5:0]               opcode, func;
    logic [4:0]               rs, rt, rd;
    logic signed [15:0]       imm16;
    logic signed [31:0]       lui32;
    logic signed [DATA_W-1:0] imm_sext, imm_zext, imm_lui, rs_val, rt_val, b_dec;
    op_t                      op_dec;
    logic                     use_imm;
    logic signed [DATA_W-1:0] imm_dec;

    assign opcode   = instr_p0[31:26];
    assign rs       = instr_p0[25:21];
    assign rt       = instr_p0[20:16];
    assign rd       = instr_p0[15:11];
    assign func     = instr_p0[5:0];
    assign imm16    = instr_p0[15:0];
    assign lui32    = {instr_p0[15:0], 16'h0000};
    assign imm_sext = DATA_W'(imm16);
    assign imm_zext = DATA_W'(instr_p0[15:0]);
    assign imm_lui  = DATA_W'(lui32);
    assign rs_val   = reg_valid(rs) ? regs[rs] : '0;
    assign rt_val   = reg_valid(rt) ? regs[rt] : '0;
    assign b_dec    = use_imm ? imm_dec : rt_val;

    always_comb begin
        op_dec  = OP_ILL;
        use_imm = 1'b0;
        imm_dec = imm_sext;
        case (opcode)
            6'h00: begin
                case (func)
                    6'h20: op_dec = OP_ADD;
                    6'h21: op_dec = OP_ADDU;
                    6'h22: op_dec = OP_SUB;
                    6'h23: op_dec = OP_SUBU;
                    6'h24: op_dec = OP_AND;
                    6'h25: op_dec = OP_OR;
                    6'h26: op_dec = OP_XOR;
                    6'h27: op_dec = OP_NOR;
                    6'h2A: op_dec = OP_SLT;
                    6'h2B: op_dec = OP_SLTU;
                    6'h00: op_dec = OP_SLL;
                    6'h02: op_dec = OP_SRL;
                    6'h03: op_dec = OP_SRA;
                    default: op_dec = OP_ILL;
                endcase
            end
            6'h08: begin op_dec = OP_ADD;   use_imm = 1'b1; end
            6'h09: begin op_dec = OP_ADDU;  use_imm = 1'b1; end
            6'h0A: begin op_dec = OP_SLT;   use_imm = 1'b1; end
            6'h0B: begin op_dec = OP_SLTU;  use_imm = 1'b1; end
            6'h0C: begin op_dec = OP_AND;   use_imm = 1'b1; imm_dec = imm_zext; end
            6'h0D: begin op_dec = OP_OR;    use_imm = 1'b1; imm_dec = imm_zext; end
            6'h0E: begin op_dec = OP_XOR;   use_imm = 1'b1; imm_dec = imm_zext; end
            6'h0F: begin op_dec = OP_PASSB; use_imm = 1'b1; imm_dec = imm_lui;  end
            default: op_dec = OP_ILL;
        endcase
    end

    // Execute on the latched operands
    logic signed [DATA_W-1:0] sum, diff, alu_res;
    logic [1:0]               alu_stat;
    logic                     wb_wen;

    assign sum    = a_p1 + b_p1;
    assign diff   = a_p1 - b_p1;
    assign wb_wen = (alu_stat == 2'b00) && reg_valid(dst_p1);

    always_comb begin
        alu_res  = '0;
        alu_stat = 2'b00;
        case (op_p1)
            OP_ADD:   begin alu_res = sum;  if (add_ovf(a_p1, b_p1, sum))  alu_stat = 2'b01; end
            OP_SUB:   begin alu_res = diff; if (sub_ovf(a_p1, b_p1, diff)) alu_stat = 2'b01; end
            OP_ADDU:  alu_res = sum;
            OP_SUBU:  alu_res = diff;
            OP_AND:   alu_res = a_p1 & b_p1;
            OP_OR:    alu_res = a_p1 | b_p1;
            OP_XOR:   alu_res = a_p1 ^ b_p1;
            OP_NOR:   alu_res = ~(a_p1 | b_p1);
            OP_SLT:   alu_res = DATA_W'(a_p1 < b_p1);
            OP_SLTU:  alu_res = DATA_W'($unsigned(a_p1) < $unsigned(b_p1));
            OP_SLL:   alu_res = b_p1 << shamt_p1;
            OP_SRL:   alu_res = $unsigned(b_p1) >> shamt_p1;
            OP_SRA:   alu_res = b_p1 >>> shamt_p1;
            OP_PASSB: alu_res = b_p1;
            default:  begin alu_res = '0; alu_stat = 2'b10; end
        endcase
    end

    // Stage boundary: IDLE capture -> DECODE operand latch
    always_ff @(posedge clk) begin
        if (state == IDLE && instr_valid) instr_p0 <= instr;
        if (state == DECODE) begin
            a_p1     <= rs_val;
            b_p1     <= b_dec;
            op_p1    <= op_dec;
            shamt_p1 <= instr_p0[10:6];
            dst_p1   <= (opcode == 6'h00) ? rd : rt;
        end
    end

    // Stage boundary: EXEC -> WB result capture and register write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            result        <= '0;
            result_dst    <= '0;
            result_wen    <= 1'b0;
            result_status <= 2'b00;
        end else begin
            if (state == IDLE && dbg_we && reg_valid(dbg_addr)) regs[dbg_addr] <= dbg_wdata;
            if (state == EXEC) begin
                result        <= alu_res;
                result_dst    <= dst_p1;
                result_wen    <= wb_wen;
                result_status <= alu_stat;
                if (wb_wen) regs[dst_p1] <= alu_res;
            end
        end
    end

endmodule

// File: tb/tb_mips_multicycle_exec.sv
// Directed bench for mips_multicycle_exec: instruction vector table plus latency, stall and reset sequences.
module tb_mips_multicycle_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic [4:0]  result_dst;
    logic        result_wen;
    logic [1:0]  result_status;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    int checks = 0;
    int errors = 0;

    mips_multicycle_exec #(.DATA_W(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .result_valid(result_valid), .result_ready(result_ready), .result(result),
        .result_dst(result_dst), .result_wen(result_wen), .result_status(result_status),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] res;
        logic [4:0]  dst;
        logic        wen;
        logic [1:0]  st;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
        dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
        tick();
        dbg_we = 1'b0;
    endtask

    task automatic dbg_read(input logic [4:0] a, output logic [31:0] d);
        dbg_raddr = a;
        #1;
        d = dbg_rdata;
    endtask

    // Offers an instruction and waits (bounded) until the unit sits in WB.
    task automatic issue(input logic [31:0] ins, output logic ok);
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin tick(); n++; end
        if (!instr_ready) begin
            chk("ready_timeout", 0, 1);
            ok = 1'b0;
            return;
        end
        instr = ins; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        n = 0;
        while (!result_valid && n < 20) begin tick(); n++; end
        ok = result_valid;
        if (!ok) chk("result_timeout", 0, 1);
    endtask

    initial begin
        logic        ok;
        logic [31:0] rd;
        logic [31:0] first;

        //            instr         R1            R2            result        dst  wen  st
        vecs[0]  = '{32'h00221821, 32'h00000005, 32'h00000007, 32'h0000000C, 5'd3, 1'b1, 2'b00};
        vecs[1]  = '{32'h00222020, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'd4, 1'b0, 2'b01};
        vecs[2]  = '{32'h00221822, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 5'd3, 1'b1, 2'b00};
        vecs[3]  = '{32'h00221822, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'd3, 1'b0, 2'b01};
        vecs[4]  = '{32'h00221823, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 5'd3, 1'b1, 2'b00};
        vecs[5]  = '{32'h00221824, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'd3, 1'b1, 2'b00};
        vecs[6]  = '{32'h00221825, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 5'd3, 1'b1, 2'b00};
        vecs[7]  = '{32'h00221826, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 5'd3, 1'b1, 2'b00};
        vecs[8]  = '{32'h00221827, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 5'd3, 1'b1, 2'b00};
        vecs[9]  = '{32'h0022182A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'd3, 1'b1, 2'b00};
        vecs[10] = '{32'h0022182B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'd3, 1'b1, 2'b00};
        vecs[11] = '{32'h00012903, 32'h80000000, 32'h00000000, 32'hF8000000, 5'd5, 1'b1, 2'b00};
        vecs[12] = '{32'h00012902, 32'h80000000, 32'h00000000, 32'h08000000, 5'd5, 1'b1, 2'b00};
        vecs[13] = '{32'h00012900, 32'h80000001, 32'h00000000, 32'h00000010, 5'd5, 1'b1, 2'b00};
        vecs[14] = '{32'h2023FFFF, 32'h00000005, 32'h00000000, 32'h00000004, 5'd3, 1'b1, 2'b00};
        vecs[15] = '{32'h20230001, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 5'd3, 1'b0, 2'b01};
        vecs[16] = '{32'h24230001, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 5'd3, 1'b1, 2'b00};
        vecs[17] = '{32'h2823FFFF, 32'hFFFFFFFE, 32'h00000000, 32'h00000001, 5'd3, 1'b1, 2'b00};
        vecs[18] = '{32'h2C23FFFF, 32'h00000005, 32'h00000000, 32'h00000001, 5'd3, 1'b1, 2'b00};
        vecs[19] = '{32'h3023FFFF, 32'h12345678, 32'h00000000, 32'h00005678, 5'd3, 1'b1, 2'b00};
        vecs[20] = '{32'h34238000, 32'h12340000, 32'h00000000, 32'h12348000, 5'd3, 1'b1, 2'b00};
        vecs[21] = '{32'h3823FFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFF0000, 5'd3, 1'b1, 2'b00};
        vecs[22] = '{32'h3C231234, 32'hAAAAAAAA, 32'h00000000, 32'h12340000, 5'd3, 1'b1, 2'b00};
        vecs[23] = '{32'h3C238000, 32'h00000000, 32'h00000000, 32'h80000000, 5'd3, 1'b1, 2'b00};
        vecs[24] = '{32'h8C230000, 32'h00000005, 32'h00000007, 32'h00000000, 5'd3, 1'b0, 2'b10};
        vecs[25] = '{32'h0022183F, 32'h00000005, 32'h00000007, 32'h00000000, 5'd3, 1'b0, 2'b10};
        vecs[26] = '{32'h00220021, 32'h00000005, 32'h00000007, 32'h0000000C, 5'd0, 1'b0, 2'b00};

        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; result_ready = 1'b1;
        dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_raddr = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_instr_ready", instr_ready, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_dst", result_dst, 0);
        chk("rst_wen", result_wen, 0);
        chk("rst_status", result_status, 0);
        dbg_read(5'd1, rd); chk("rst_r1", rd, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_instr_ready", instr_ready, 1);

        // Latency and throughput of a single addu
        dbg_write(5'd1, 32'd5);
        dbg_write(5'd2, 32'd7);
        instr = 32'h00221821; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        chk("lat_ready_busy", instr_ready, 0);
        chk("lat_valid_n1", result_valid, 0);
        tick();
        chk("lat_valid_n2", result_valid, 0);
        tick();
        chk("lat_valid_n3", result_valid, 1);
        chk("lat_result", result, 32'd12);
        chk("lat_dst", result_dst, 3);
        chk("lat_wen", result_wen, 1);
        tick();
        chk("lat_ready_n4", instr_ready, 1);
        dbg_read(5'd3, rd); chk("lat_r3", rd, 32'd12);

        // Backpressure in WB
        result_ready = 1'b0;
        dbg_write(5'd1, 32'd3);
        dbg_write(5'd2, 32'd4);
        issue(32'h00221821, ok);
        if (ok) begin
            first = result;
            chk("stall_result", first, 32'd7);
            for (int k = 0; k < 5; k++) begin
                dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h55;
                tick();
                chk($sformatf("stall%0d_valid", k), result_valid, 1);
                chk($sformatf("stall%0d_result", k), result, first);
                chk($sformatf("stall%0d_ready", k), instr_ready, 0);
            end
            dbg_we = 1'b0;
            dbg_read(5'd3, rd); chk("stall_r3", rd, 32'd7);
            result_ready = 1'b1;
            tick();
            chk("stall_release_ready", instr_ready, 1);
            dbg_read(5'd9, rd); chk("stall_dbg_ignored", rd, 0);
        end
        result_ready = 1'b1;

        // Reset while the instruction is in EXEC
        dbg_write(5'd1, 32'd5);
        dbg_write(5'd2, 32'd7);
        instr = 32'h00221821; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort_ready", instr_ready, 0);
        chk("abort_valid", result_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_wen", result_wen, 0);
        rst_n = 1'b1;
        tick();
        chk("abort_valid_after", result_valid, 0);
        chk("abort_ready_after", instr_ready, 1);
        dbg_read(5'd3, rd); chk("abort_r3", rd, 0);
        dbg_read(5'd1, rd); chk("abort_r1", rd, 0);

        // Instruction vector table
        for (int i = 0; i < NV; i++) begin
            logic [31:0] exp_reg;
            if (vecs[i].dst != 5'd0) dbg_write(vecs[i].dst, 32'hDEADBEEF);
            dbg_write(5'd1, vecs[i].r1);
            dbg_write(5'd2, vecs[i].r2);
            issue(vecs[i].ins, ok);
            if (ok) begin
                chk($sformatf("vec%0d_result", i), result, vecs[i].res);
                chk($sformatf("vec%0d_dst", i), result_dst, vecs[i].dst);
                chk($sformatf("vec%0d_wen", i), result_wen, vecs[i].wen);
                chk($sformatf("vec%0d_status", i), result_status, vecs[i].st);
                tick();
                exp_reg = vecs[i].wen ? vecs[i].res : ((vecs[i].dst == 5'd0) ? 32'h0 : 32'hDEADBEEF);
                dbg_read(vecs[i].dst, rd);
                chk($sformatf("vec%0d_regfile", i), rd, exp_reg);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
